instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the main-decoder/ALU-control block.
- Owns the PC and issues word requests to instruction memory over a request/valid handshake with variable latency.
- Registers the returned word and presents `Opcode`/`Func` fields to decode.
- Takes branch/jump redirects back from decode/execute to form the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction memory request, held until imem_valid
- imem_addr  out  ADDR_W  word-aligned fetch address (= pc)
- imem_rdata  in  32  returned instruction word
- imem_valid  in  1  imem_rdata valid this cycle; honoured only in FETCH
- stall  in  1  downstream cannot accept; holds issued instruction
- branch_taken  in  1  Branch & ALU zero for the issued instruction
- branch_offset  in  32  sign-extended immediate of the issued instruction
- jump  in  1  jump decoded for the issued instruction
- jump_index  in  26  instr[25:0] of the issued instruction
- instr  out  32  issued instruction register
- Opcode  out  6  instr[31:26]
- Func  out  6  instr[5:0]
- instr_valid  out  1  instr is valid for decode
- pc  out  ADDR_W  address of instr / current fetch
- pc_plus4  out  ADDR_W  pc + 4
- instr_count  out  32  perf counter (see Optional Feature)
- stall_count  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, state=IDLE, counters=0.
- Clock and reset: one clock; reset is asynchronous and active-high (`clk`, `rst`).
- FSM states: IDLE, FETCH, ISSUE.
- IDLE: one cycle after reset release, then go to FETCH. imem_valid is ignored here, so a stale response arriving after reset mid-fetch is dropped.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_valid: instr<=imem_rdata, instr_valid<=1 next cycle, go to ISSUE.
  - Otherwise stay; pc and imem_addr are stable.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - If stall=1: hold instr, pc and state. Redirect inputs are ignored.
  - If stall=0: update pc, clear instr_valid, go to FETCH.
- Next-PC priority (ISSUE, stall=0):
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - else branch_taken: pc_plus4 + (branch_offset << 2).
  - else pc_plus4.
  - jump and branch_taken both high: jump wins.
- Arithmetic: all address math is modulo 2^ADDR_W. pc=32'hFFFF_FFFC with no redirect wraps to 0. Shifted offset bits above bit 31 are discarded.
- Alignment: pc[1:0] is always 0 by construction.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle imem_valid, then ISSUE). Each memory wait cycle adds one.
- Derived outputs: Opcode/Func/pc_plus4 are combinational from instr/pc. Opcode/Func are valid only while instr_valid=1.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined:
  - instr_count increments once per ISSUE->FETCH transition (instruction retired from fetch).
  - stall_count increments every cycle in ISSUE with stall=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports tied to 32'h0 and no counter flops are synthesised.

Decomposition:
- Shared package `mips_pkg`:
  - FSM state typedef (IDLE/FETCH/ISSUE).
  - Opcode constants: LW 6'b100011, SW 6'b101011, RTYPE 6'b000000, ADDI 6'b001000, BEQ 6'b000100, J 6'b000010.
  - RESET_PC default.
- One natural sub-module: `next_pc_logic`, a combinational mux producing pc_plus4, the branch target, the jump target and the selected next PC.

Test Plan:
- Reset then zero-wait memory returning 32'h2008_0005 at 0 -> instr_valid on cycle 3 after rst falls, Opcode=6'b001000, pc=0. Next fetch addr=4.
- imem_valid delayed 3 cycles at pc=8 -> imem_req and imem_addr=8 held for all 3 cycles, instr captured only on the valid cycle.
- ISSUE at pc=32'h40 with branch_taken=1, branch_offset=32'hFFFF_FFFE -> next imem_addr=32'h3C. With branch_offset=3 -> 32'h50.
- ISSUE at pc=32'h1000_0000 with jump=1, jump_index=26'h0000010, branch_taken=1 simultaneously -> next imem_addr=32'h1000_0040 (jump wins).
- stall=1 for 4 cycles in ISSUE with branch_taken toggling -> instr/pc unchanged, stall_count=4 (macro on) or 0 (macro off). Redirect applied only from the stall=0 cycle's inputs.
- Assert rst mid-FETCH at pc=32'h20 with a response arriving during IDLE -> pc=RESET_PC, instr_valid=0, stale word not captured. Also: pc=32'hFFFF_FFFC with no redirect -> next imem_addr=0.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS front end: the fetch FSM state type, the
// major opcode constants seen by decode, the default reset PC and helpers
// that pull the Opcode/Func fields out of an instruction word.
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } ifu_state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

  function automatic logic [5:0] func_of(input logic [31:0] word);
    return word[5:0];
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// -----------------------------------------------------------------------------
// next_pc_logic
// Combinational next-PC selection for the fetch unit.
//   i_pc            current PC (word aligned)
//   i_branch_taken  taken conditional branch for the issued instruction
//   i_branch_offset sign-extended word offset of the branch
//   i_jump          jump decoded for the issued instruction
//   i_jump_index    instr[25:0] of the jump
//   o_pc_plus4      sequential address
//   o_next_pc       selected next PC (jump > branch > sequential)
// All arithmetic is modulo 2^ADDR_W; offset bits shifted past the top of the
// address are discarded.
// -----------------------------------------------------------------------------
module next_pc_logic #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_branch_taken,
  input  logic [31:0]       i_branch_offset,
  input  logic              i_jump,
  input  logic [25:0]       i_jump_index,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic [ADDR_W-1:0] o_next_pc
);

  logic        [ADDR_W-1:0] w_pc_plus4;
  logic signed [ADDR_W-1:0] w_offset_sx;
  logic        [ADDR_W-1:0] w_branch_target;
  logic        [ADDR_W-1:0] w_jump_target;

  assign w_pc_plus4      = i_pc + ADDR_W'(4);
  assign w_offset_sx     = ADDR_W'($signed(i_branch_offset));
  assign w_branch_target = w_pc_plus4 + $unsigned(w_offset_sx <<< 2);
  // Jump keeps the 256 MB region of the sequential address.
  assign w_jump_target   = {w_pc_plus4[ADDR_W-1:28], i_jump_index, 2'b00};

  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_jump) begin
      o_next_pc = w_jump_target;
    end else if (i_branch_taken) begin
      o_next_pc = w_branch_target;
    end
  end

  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: owns the PC, requests words from instruction memory over a
// req/valid handshake with variable latency, registers the returned word and
// presents it (with Opcode/Func) to decode. Redirects from decode/execute
// select the next PC when the issued instruction leaves.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   imem_req/addr     memory request (held until imem_valid), word address
//   imem_rdata/valid  returned word, honoured only in FETCH
//   stall             downstream holds the issued instruction
//   branch_taken, branch_offset, jump, jump_index   redirect inputs
//   instr, Opcode, Func, instr_valid                issued instruction
//   pc, pc_plus4      address of instr and its successor
//   instr_count, stall_count   performance counters
//
// Build option: define IFU_PERF_CNT_EN to implement the counters; otherwise
// both counter ports are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  output logic [31:0]       instr,
  output logic [5:0]        Opcode,
  output logic [5:0]        Func,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [31:0]       instr_count,
  output logic [31:0]       stall_count
);

  ifu_state_e        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic              r_instr_valid;
  logic              r_imem_req;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_next_pc;

  next_pc_logic #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .i_pc            (r_pc),
    .i_branch_taken  (branch_taken),
    .i_branch_offset (branch_offset),
    .i_jump          (jump),
    .i_jump_index    (jump_index),
    .o_pc_plus4      (w_pc_plus4),
    .o_next_pc       (w_next_pc)
  );

  // Fetch FSM with registered request/valid outputs.
  // IDLE lasts one cycle after reset so a response belonging to a fetch that
  // was cut short by reset is dropped rather than captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_valid) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Redirect inputs only matter on the cycle the instruction leaves.
          if (!stall) begin
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= FETCH;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_instr_valid <= 1'b0;
          r_imem_req    <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_instr_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_count <= 32'h0;
      r_stall_count <= 32'h0;
    end else if (r_state == ISSUE) begin
      if (stall) begin
        r_stall_count <= r_stall_count + 32'd1;
      end else begin
        r_instr_count <= r_instr_count + 32'd1;
      end
    end
  end

  assign instr_count = r_instr_count;
  assign stall_count = r_stall_count;
`else
  assign instr_count = 32'h0;
  assign stall_count = 32'h0;
`endif

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign Opcode      = opcode_of(r_instr);
  assign Func        = func_of(r_instr);
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Transaction-level bench: each fetched instruction is walked through its
// memory wait, issue and stall cycles while a reference model tracks the
// architectural PC, the issued word and the performance counts.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic [31:0] instr;
  logic [5:0]  Opcode;
  logic [5:0]  Func;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_count;
  logic [31:0] stall_count;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .instr         (instr),
    .Opcode        (Opcode),
    .Func          (Func),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr_count   (instr_count),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] m_pc      = 32'h0;
  logic [31:0] m_instr   = 32'h0;
  int unsigned m_retired = 0;
  int unsigned m_stalls  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Architectural next-PC rule: jump beats branch beats sequential.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic bt,
                                             input logic [31:0] off, input logic j,
                                             input logic [25:0] idx);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ({6'b0, idx} * 32'd4);
    if (bt) return seq + off * 32'd4;
    return seq;
  endfunction

  function automatic logic [31:0] exp_icount();
`ifdef IFU_PERF_CNT_EN
    return 32'(m_retired);
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_scount();
`ifdef IFU_PERF_CNT_EN
    return 32'(m_stalls);
`else
    return 32'h0;
`endif
  endfunction

  // Entered at a falling edge with the DUT expected in FETCH at m_pc; leaves
  // at the falling edge after the instruction retires (DUT back in FETCH).
  task automatic fetch_one(input int lat, input logic [31:0] word, input int nstall,
                           input logic f_bt, input logic [31:0] f_off,
                           input logic f_j, input logic [25:0] f_idx);
    check_eq("fetch_req", 32'(imem_req), 32'd1);
    check_eq("fetch_addr", imem_addr, m_pc);
    check_eq("fetch_vld", 32'(instr_valid), 32'd0);
    for (int i = 0; i < lat; i++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check_eq("wait_req", 32'(imem_req), 32'd1);
      check_eq("wait_addr", imem_addr, m_pc);
      check_eq("wait_vld", 32'(instr_valid), 32'd0);
      check_eq("wait_instr", instr, m_instr);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    m_instr    = word;
    check_eq("issue_vld", 32'(instr_valid), 32'd1);
    check_eq("issue_instr", instr, word);
    check_eq("issue_opcode", 32'(Opcode), 32'(word[31:26]));
    check_eq("issue_func", 32'(Func), 32'(word[5:0]));
    check_eq("issue_pc", pc, m_pc);
    check_eq("issue_pc4", pc_plus4, m_pc + 32'd4);
    check_eq("issue_req", 32'(imem_req), 32'd0);
    for (int s = 0; s < nstall; s++) begin
      stall         = 1'b1;
      branch_taken  = ~branch_taken;
      jump          = 1'($urandom);
      branch_offset = $urandom;
      jump_index    = 26'($urandom);
      imem_valid    = 1'($urandom);
      @(negedge clk);
      m_stalls++;
      check_eq("stall_instr", instr, m_instr);
      check_eq("stall_pc", pc, m_pc);
      check_eq("stall_vld", 32'(instr_valid), 32'd1);
    end
    stall         = 1'b0;
    branch_taken  = f_bt;
    branch_offset = f_off;
    jump          = f_j;
    jump_index    = f_idx;
    imem_valid    = 1'b0;
    @(negedge clk);
    branch_taken  = 1'b0;
    jump          = 1'b0;
    branch_offset = 32'h0;
    jump_index    = 26'h0;
    m_pc = model_next(m_pc, f_bt, f_off, f_j, f_idx);
    m_retired++;
    check_eq("instr_count", instr_count, exp_icount());
    check_eq("stall_count", stall_count, exp_scount());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] off;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_vld", 32'(instr_valid), 32'd0);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_icnt", instr_count, 32'h0);
    check_eq("rst_scnt", stall_count, 32'h0);
    rst = 1'b0;
    @(negedge clk);  // one IDLE cycle has elapsed

    // Zero-wait ADDI at 0, then sequential to 4 and 8
    fetch_one(0, 32'h2008_0005, 0, 1'b0, 32'h0, 1'b0, 26'h0);
    fetch_one(1, 32'h8C01_0000, 0, 1'b0, 32'h0, 1'b0, 26'h0);
    // Three wait cycles at 8, branch to 0x40
    fetch_one(3, 32'h0000_0020, 0, 1'b1, 32'h0000_000D, 1'b0, 26'h0);
    // Backward branch 0x40 -> 0x3C, sequential to 0x40, forward to 0x50
    fetch_one(0, 32'h1000_FFFE, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
    fetch_one(0, 32'hAC02_0004, 0, 1'b0, 32'h0, 1'b0, 26'h0);
    fetch_one(2, 32'h1000_0003, 0, 1'b1, 32'h0000_0003, 1'b0, 26'h0);
    // Long branch to 0x1000_0000
    fetch_one(0, 32'h1000_0000, 0, 1'b1, 32'h03FF_FFEB, 1'b0, 26'h0);
    // Four stall cycles with toggling redirects, then jump and branch together
    fetch_one(1, 32'h0800_0010, 4, 1'b1, 32'h0000_0100, 1'b1, 26'h000_0010);
    // Branch with high offset bits discarded to 0xF000_0000, jump to top word
    fetch_one(0, 32'h1000_1234, 0, 1'b1, 32'hF7FF_FFEF, 1'b0, 26'h0);
    fetch_one(0, 32'h0BFF_FFFF, 0, 1'b0, 32'h0, 1'b1, 26'h3FF_FFFF);
    // 0xFFFF_FFFC wraps to 0
    fetch_one(1, 32'h0000_0000, 0, 1'b0, 32'h0, 1'b0, 26'h0);

    // Randomised traffic
    for (int k = 0; k < 40; k++) begin
      fetch_one(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)),
                1'($urandom), $urandom, ($urandom_range(0, 3) == 0), 26'($urandom));
    end

    // Head to 0x20 and cut the fetch there with reset
    off = (32'h20 - m_pc - 32'd4) >> 2;
    fetch_one(0, 32'h1000_0000, 1, 1'b1, off, 1'b0, 26'h0);
    check_eq("pre_rst_addr", imem_addr, 32'h20);
    imem_valid = 1'b0;
    @(negedge clk);
    rst        = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("arst_pc", pc, 32'h0);
    check_eq("arst_vld", 32'(instr_valid), 32'd0);
    check_eq("arst_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);  // response was present throughout IDLE
    check_eq("stale_instr", instr, 32'h0);
    check_eq("stale_vld", 32'(instr_valid), 32'd0);
    imem_valid = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_retired = 0; m_stalls = 0;
    fetch_one(0, 32'h2008_0005, 2, 1'b0, 32'h0, 1'b0, 26'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
